// File: rtl/rev_alu_pkg.sv
// Shared opcodes, FSM states and reversible gate helpers
// for the bit-serial reversible ALU controller.
package rev_alu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_PASSA = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Fredkin controlled swap, Q output: c ? y : x
  function automatic logic fred_q(
    input logic c,
    input logic x,
    input logic y
  );
    return (~c & x) | (c & y);
  endfunction

  function automatic logic hng_r(
    input logic a,
    input logic b,
    input logic c
  );
    return a ^ b ^ c;
  endfunction

  function automatic logic hng_s(
    input logic a,
    input logic b,
    input logic c,
    input logic d
  );
    return ((a ^ b) & c) ^ (a & b) ^ d;
  endfunction

endpackage

// File: rtl/rev_alu_bit.sv
// One-bit reversible ALU slice: HNG full adder plus
// Fredkin selection; garbage outputs are never formed.
module rev_alu_bit
  import rev_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       s,
  output logic       cout
);

  logic sub;
  logic bx;
  logic sum;
  logic cy;
  logic and_v;
  logic or_v;
  logic xor_v;
  logic m_lo;
  logic m_hi;
  logic arith;

  assign sub   = ~op[2] & ~op[1] & op[0];
  assign bx    = fred_q(sub, b, ~b);
  assign sum   = hng_r(a, bx, cin);
  assign cy    = hng_s(a, bx, cin, 1'b0);
  assign and_v = fred_q(a, 1'b0, b);
  assign or_v  = fred_q(a, b, 1'b1);
  assign xor_v = hng_r(a, b, 1'b0);

  assign m_lo = fred_q(op[1], sum,
                       fred_q(op[0], and_v, or_v));
  assign m_hi = fred_q(op[1],
                       fred_q(op[0], xor_v, a), 1'b0);
  assign s    = fred_q(op[2], m_lo, m_hi);

  assign arith = ~op[2] & ~op[1];
  assign cout  = fred_q(arith, 1'b0, cy);

endmodule

// File: rtl/rev_serial_alu_ctrl.sv
// Bit-serial controller around one reversible ALU slice.
// Define REV_SERIAL_OVF_EN to enable the signed overflow flag.
module rev_serial_alu_ctrl
  import rev_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nx;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sl_s;
  logic             sl_cout;
  logic             last;

  rev_alu_bit u_bit (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .op   (op_q),
    .s    (sl_s),
    .cout (sl_cout)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign res_nx = {sl_s, res_sr[WIDTH-1:1]};

`ifdef REV_SERIAL_OVF_EN
  logic arith;
  assign arith = ~op_q[2] & ~op_q[1];

  // carry flop still holds the MSB carry-in on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == S_RUN && !abort && last) begin
      ovf <= arith & (carry ^ sl_cout);
    end
  end
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_q   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            a_sr  <= a;
            b_sr  <= b;
            op_q  <= op;
            cnt   <= '0;
            carry <= (op == OP_SUB);
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nx;
            carry  <= sl_cout;
            cnt    <= cnt + CW'(1);
            if (last) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= res_nx;
              cout   <= sl_cout;
              zero   <= ~|res_nx;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rev_serial_alu_ctrl.sv
// Randomized and directed bench for rev_serial_alu_ctrl
// against an arithmetic reference model.
module tb_rev_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         ovf;

  int           checks = 0;
  int           fails = 0;
  logic [W-1:0] last_res = '0;

  rev_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] o,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       output logic [W-1:0] r,
                       output logic c,
                       output logic z,
                       output logic v);
    int s;
    c = 1'b0;
    v = 1'b0;
    s = 0;
    case (o)
      3'd0: begin
        s = int'(x) + int'(y);
        r = W'(s);
        c = (s > 255);
        v = (x[7] == y[7]) && (r[7] != x[7]);
      end
      3'd1: begin
        s = int'(x) - int'(y);
        r = W'(s);
        c = (x >= y);
        v = (x[7] != y[7]) && (r[7] != x[7]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x;
      default: r = '0;
    endcase
    z = (r == 0);
`ifndef REV_SERIAL_OVF_EN
    v = 1'b0;
`endif
  endtask

  // inj > 0 pulses a stray start with a=FF at that run cycle
  task automatic run_op(input logic [2:0] o,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input int inj);
    logic [W-1:0] er;
    logic ec, ez, ev, got;
    int cyc;
    model(o, x, y, er, ec, ez, ev);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    op = 3'($urandom_range(0, 7));
    check("busy_run", busy, 1);
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < W + 4) begin
      if (cyc == inj) begin
        start = 1'b1; a = 8'hFF;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) got = 1'b1;
    end
    check("latency", cyc, W + 1);
    check("result", result, er);
    check("cout", cout, ec);
    check("zero", zero, ez);
    check("ovf", ovf, ev);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    last_res = er;
  endtask

  initial begin
    int dcount;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {cout, zero, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 8'h7F, 8'h01, 0);
    run_op(3'd1, 8'h05, 8'h07, 0);
    run_op(3'd1, 8'h07, 8'h07, 0);
    for (int i = 2; i < 8; i++) run_op(3'(i), 8'hF0, 8'h3C, 0);
    run_op(3'd0, 8'hFF, 8'h01, 0);
    run_op(3'd1, 8'h80, 8'h01, 0);

    run_op(3'd0, 8'h01, 8'h01, 3);
    check("ignore_start", result, 8'h02);

    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_result", result, last_res);
    dcount = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_nodone", dcount, 0);
    run_op(3'd4, 8'hA5, 8'h0F, 0);

    start = 1'b1; abort = 1'b1; op = 3'd0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_wins", busy, 0);
    dcount = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("abort_wins_idle", dcount, 0);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), W'($urandom),
             W'($urandom), 0);

    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_flags", {cout, zero, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 8'h03, 8'h04, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/rev_serial_alu_ctrl.md
REV_SERIAL_ALU_CTRL -- requirements
Module: rev_serial_alu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request operation; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous cancel of operation in progress.
REQ-006 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSA, 110/111 reserved.
REQ-007 SHALL have ports a, b  input  WIDTH  operands, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  WIDTH  last completed result, held until next completion.
REQ-011 SHALL have ports cout, zero, ovf  output  1 each  carry/not-borrow, result==0, signed overflow.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 SHALL accept start only in IDLE with abort low: latch a, b, op into shift registers; clear bit counter; preset carry flop to 0 (ADD) or 1 (SUB, b inverted per bit), 0 otherwise; go to RUN.
REQ-014 SHALL in RUN process one bit per cycle, LSB first, through one 1-bit reversible ALU slice; shift sum bit into result shift register MSB; update carry flop.
REQ-015 SHALL leave RUN after exactly WIDTH cycles (counter WIDTH-1 reached) to DONE; done high exactly in DONE cycle; DONE always returns to IDLE next cycle.
REQ-016 SHALL give latency: start sampled at edge t -> done high during cycle t+WIDTH+1; next start accepted at edge after DONE.
REQ-017 SHALL ignore start in RUN and DONE (no re-latch, no queueing).
REQ-018 SHALL in RUN or DONE with abort high return to IDLE next edge, no done pulse, result/flags unchanged; abort and start together in IDLE: abort wins, nothing accepted.
REQ-019 SHALL update result, cout, zero, ovf only on the RUN->DONE transition.
REQ-020 SHALL set cout = final carry for ADD/SUB (SUB: 1 = no borrow), 0 for logic ops.
REQ-021 SHALL set zero = (result == 0) for all opcodes.
REQ-022 SHALL for reserved opcodes produce result 0, cout 0, ovf 0, zero 1, with normal timing.
REQ-023 SHALL discard slice garbage outputs; they never affect state.

Reset
REQ-024 SHALL on rst_n low, immediately: state IDLE, busy 0, done 0, result 0, cout 0, zero 0, ovf 0, counter/carry/shift registers 0.
REQ-025 SHALL on reset mid-RUN drop the operation silently; first start after release behaves as from power-up.

Configuration
REQ-026 SHALL with macro REV_SERIAL_OVF_EN defined compute ovf = carry into MSB XOR carry out of MSB for ADD/SUB (0 for logic ops), via an extra flop holding MSB carry-in.
REQ-027 SHALL without REV_SERIAL_OVF_EN tie ovf to constant 0 and omit the extra flop; all other behaviour identical.

Structure
REQ-028 SHALL place opcode encodings (ADD..PASSA), FSM state encoding and the default WIDTH constant in shared package rev_alu_pkg.
REQ-029 SHALL instantiate exactly one sub-module rev_alu_bit: 1-bit combinational slice (a, b, cin, op -> s, cout) built from the team's HNG full-adder and Fredkin selection gates; no arithmetic operators in it.
REQ-030 SHALL keep all sequential logic in rev_serial_alu_ctrl.

Verification (WIDTH=8)
REQ-031 SHALL cover: ADD a=0x7F b=0x01 start at edge 0 -> done edge 9, result 0x80, cout 0, zero 0, ovf 1 (macro on) / 0 (off).
REQ-032 SHALL cover: SUB a=0x05 b=0x07 -> result 0xFE, cout 0; SUB a=0x07 b=0x07 -> result 0x00, cout 1, zero 1.
REQ-033 SHALL cover: AND 0xF0/0x3C -> 0x30; OR -> 0xFC; XOR -> 0xCC; PASSA -> 0xF0; op=111 -> 0x00, zero 1; cout 0 each.
REQ-034 SHALL cover: second start (a=0xFF) pulsed at edge 3 of a running ADD 0x01+0x01 -> ignored, result 0x02 at edge 9.
REQ-035 SHALL cover: abort at edge 4 of ADD 0x10+0x20 after prior result 0x02 -> IDLE at edge 5, no done, result stays 0x02; next start runs normally.
REQ-036 SHALL cover: rst_n low asynchronously mid-RUN -> busy/done/result/flags 0 immediately; post-release ADD 0x03+0x04 -> 0x07 at start+9.
